// File: rtl/traceback_window.sv
// Viterbi traceback engine: walks the survivor memory back D steps from a given end state and
// emits the oldest L decoded bits of the window, oldest-first, over a valid/ready handshake.
module traceback_window #(
    parameter int unsigned M = 6,
    parameter int unsigned D = 40,
    parameter int unsigned L = 8,
    localparam int unsigned AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_time,
    input  logic [M-1:0]  start_state,
    input  logic          use_state0,
    output logic          busy,
    output logic [AW-1:0] rd_time,
    output logic [M-1:0]  rd_state,
    input  logic          rd_surv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_last
);

    localparam int unsigned CW = $clog2(L + 1);
    localparam logic [AW-1:0] PushFrom = AW'(D - L);
    localparam logic [AW-1:0] LastStep = AW'(D - 1);
    localparam logic [CW-1:0] OneCnt   = CW'(1);

    if (L < 1 || L > D || D < 2) begin : gen_param_check
        $error("traceback_window: requires 1 <= L <= D and D >= 2");
    end

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_time_q, rd_time_d;
    logic [M-1:0]    rd_state_q, rd_state_d;
    logic [AW-1:0]   step_q, step_d;
    logic [L-1:0]    lifo_q, lifo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    prev_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_time_q  <= '0;
            rd_state_q <= '0;
            step_q     <= '0;
            lifo_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_time_q  <= rd_time_d;
            rd_state_q <= rd_state_d;
            step_q     <= step_d;
            lifo_q     <= lifo_d;
            cnt_q      <= cnt_d;
        end
    end

    // Predecessor state: shift right, survivor bit enters at the MSB.
    always_comb begin
        prev_state        = rd_state_q >> 1;
        prev_state[M-1]   = rd_surv;
    end

    always_comb begin
        state_d    = state_q;
        rd_time_d  = rd_time_q;
        rd_state_d = rd_state_q;
        step_d     = step_q;
        lifo_d     = lifo_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rd_time_d  = start_time;
                    rd_state_d = use_state0 ? '0 : start_state;
                    step_d     = '0;
                    lifo_d     = '0;
                    cnt_d      = '0;
                    state_d    = StAddr;
                end
            end
            StAddr: state_d = StData;
            StData: begin
                // Newest push lands in bit 0, so bit 0 is always the LIFO top.
                if (step_q >= PushFrom) begin
                    lifo_d = (lifo_q << 1) | L'(rd_state_q[0]);
                    cnt_d  = cnt_q + OneCnt;
                end
                rd_state_d = prev_state;
                rd_time_d  = (rd_time_q == '0) ? LastStep : rd_time_q - AW'(1);
                step_d     = step_q + AW'(1);
                state_d    = (step_q == LastStep) ? StDrain : StAddr;
            end
            StDrain: begin
                if (out_ready) begin
                    lifo_d = lifo_q >> 1;
                    cnt_d  = cnt_q - OneCnt;
                    if (cnt_q == OneCnt) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDrain);
        out_bit   = out_valid & lifo_q[0];
        out_last  = out_valid & (cnt_q == OneCnt);
        rd_time   = rd_time_q;
        rd_state  = rd_state_q;
    end

endmodule

// File: tb/tb_traceback_window.sv
// Directed bench for traceback_window at M=3, D=8, L=4 with a registered survivor-memory model.
module tb_traceback_window;

    localparam int unsigned M  = 3;
    localparam int unsigned D  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_time;
    logic [M-1:0]  start_state;
    logic          use_state0;
    logic          busy;
    logic [AW-1:0] rd_time;
    logic [M-1:0]  rd_state;
    logic          rd_surv;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          out_last;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_mode = 0;

    traceback_window #(.M(M), .D(D), .L(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_time (start_time),
        .start_state(start_state),
        .use_state0 (use_state0),
        .busy       (busy),
        .rd_time    (rd_time),
        .rd_state   (rd_state),
        .rd_surv    (rd_surv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Survivor memory with one-cycle read latency.
    // mode 0: 1 iff state==0; mode 1: all ones; mode 2: all zeros; mode 3: time LSB.
    always @(posedge clk) begin
        case (mem_mode)
            0:       rd_surv <= (rd_state == '0);
            1:       rd_surv <= 1'b1;
            2:       rd_surv <= 1'b0;
            default: rd_surv <= rd_time[0];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".rd_time"},   32'(rd_time),   32'd0);
        chk({tag, ".rd_state"},  32'(rd_state),  32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_bit"},   32'(out_bit),   32'd0);
        chk({tag, ".out_last"},  32'(out_last),  32'd0);
    endtask

    // Runs one window; called at a sample point (#1 after a posedge) with the DUT idle.
    task automatic run_window(input logic [2:0] st, input logic [2:0] ss, input logic u0,
                              input int mode, input logic [0:3] bits, input bit hold_start,
                              input bit stall);
        logic [AW-1:0] tlog [8];
        int lat = 0;
        int b = 0;
        int stalls = 0;
        mem_mode    = mode;
        start       = 1'b1;
        start_time  = st;
        start_state = ss;
        use_state0  = u0;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        if (hold_start) begin
            start_state = ~ss;
            start_time  = st + 3'd3;
            use_state0  = ~u0;
        end else begin
            start = 1'b0;
        end
        chk("first_rd_state", 32'(rd_state), u0 ? 32'd0 : 32'(ss));
        chk("busy_after_accept", 32'(busy), 32'd1);
        tlog[0] = rd_time;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 0 && k <= 14) tlog[k / 2] = rd_time;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (out_bit || out_last) chk("out_zero_before_drain", {out_bit, out_last}, 32'd0);
        end
        chk("latency", 32'(lat), 32'd16);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] et;
            et = st - 3'(i);
            chk($sformatf("rd_time[%0d]", i), 32'(tlog[i]), 32'(et));
        end
        for (int cyc = 0; cyc < 20 && b < 4; cyc++) begin
            chk($sformatf("valid[%0d]", b), 32'(out_valid), 32'd1);
            chk($sformatf("bit[%0d]", b),   32'(out_bit),   32'(bits[b]));
            chk($sformatf("last[%0d]", b),  32'(out_last),  (b == 3) ? 32'd1 : 32'd0);
            if (stall && b == 1 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                b++;
            end
            @(posedge clk); #1;
        end
        chk("bits_delivered", 32'(b), 32'd4);
        start = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("idle_busy_2", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [2:0] st;
        logic [2:0] ss;
        logic       u0;
        int         mode;
        logic [0:3] bits;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Bits are listed in output order (first emitted on the left).
        vecs[0] = '{st: 3'd7, ss: 3'd0, u0: 1'b0, mode: 0, bits: 4'b1000};
        vecs[1] = '{st: 3'd7, ss: 3'd5, u0: 1'b0, mode: 0, bits: 4'b0100};
        vecs[2] = '{st: 3'd4, ss: 3'd3, u0: 1'b0, mode: 0, bits: 4'b0010};
        vecs[3] = '{st: 3'd7, ss: 3'd5, u0: 1'b1, mode: 0, bits: 4'b1000};
        vecs[4] = '{st: 3'd0, ss: 3'd0, u0: 1'b0, mode: 1, bits: 4'b1111};
        vecs[5] = '{st: 3'd7, ss: 3'd7, u0: 1'b0, mode: 2, bits: 4'b0000};
        vecs[6] = '{st: 3'd7, ss: 3'd0, u0: 1'b0, mode: 3, bits: 4'b1010};
        vecs[7] = '{st: 3'd2, ss: 3'd0, u0: 1'b0, mode: 3, bits: 4'b0101};

        rst         = 1'b1;
        start       = 1'b1;
        start_time  = 3'd5;
        start_state = 3'd6;
        use_state0  = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].st, vecs[i].ss, vecs[i].u0, vecs[i].mode, vecs[i].bits, 1'b0,
                       1'b0);
        end

        // Backpressure on bit 2 with start held high for the whole window.
        run_window(3'd7, 3'd0, 1'b0, 3, 4'b1010, 1'b1, 1'b1);

        // Reset during the 5th DATA cycle, then a clean window.
        mem_mode    = 0;
        start       = 1'b1;
        start_time  = 3'd7;
        start_state = 3'd0;
        use_state0  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("mid_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(busy), 32'd0);
        run_window(3'd7, 3'd5, 1'b0, 0, 4'b0100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traceback_window.md
TRACEBACK_WINDOW -- requirements
Module: traceback_window

Interface
REQ-001 Parameters (name, default, meaning): M, 6, state width in bits; D, 40, traceback depth in steps and survivor-memory depth; L, 8, decoded bits per traceback (1 <= L <= D); AW = clog2(D), time-pointer width (derived).
REQ-002 clk  in  1  clock; all logic on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a traceback; sampled only in IDLE.
REQ-005 start_time  in  AW  newest survivor-memory column to trace from.
REQ-006 start_state  in  M  end state to trace from.
REQ-007 use_state0  in  1  when high at start, the end state is forced to 0 and start_state is ignored.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 rd_time  out  AW  survivor-memory read column, registered.
REQ-010 rd_state  out  M  survivor-memory read row, registered.
REQ-011 rd_surv  in  1  survivor bit for the (rd_time, rd_state) presented in the previous cycle.
REQ-012 out_valid  out  1  a decoded bit is presented.
REQ-013 out_ready  in  1  the consumer accepts the bit.
REQ-014 out_bit  out  1  decoded bit.
REQ-015 out_last  out  1  high with the L-th bit of the window.

Function
REQ-016 The FSM SHALL have the states IDLE, ADDR, DATA and DRAIN.
REQ-017 IDLE: when start=1, the block SHALL load rd_time=start_time, rd_state=(use_state0 ? 0 : start_state) and step_cnt=0, then go to ADDR.
REQ-018 ADDR (1 cycle): rd_time and rd_state SHALL be held; next state is DATA.
REQ-019 DATA (1 cycle): the block SHALL use rd_surv for the current address and perform these actions:
- if step_cnt >= D-L, push rd_state[0] onto the LIFO;
- set rd_state <= {rd_surv, rd_state[M-1:1]};
- set rd_time <= (rd_time==0) ? D-1 : rd_time-1;
- set step_cnt <= step_cnt+1.
REQ-020 DATA exit: if step_cnt==D-1, the next state SHALL be DRAIN, otherwise ADDR.
REQ-021 A full traceback SHALL take exactly 2*D cycles from the start-accept edge to DRAIN entry.
REQ-022 The LIFO SHALL be L entries deep; its count register is clog2(L+1) bits wide.
REQ-023 DRAIN SHALL pop the LIFO so that bits leave oldest-first: the last bit pushed leaves first.
REQ-024 DRAIN: out_valid=1 and out_bit=top of the LIFO.
REQ-025 out_last=1 SHALL hold when exactly one entry remains.
REQ-026 DRAIN transfers a bit only on out_valid & out_ready.
REQ-027 While out_valid=1 and out_ready=0, out_bit and out_last SHALL be held stable.
REQ-028 After the transfer with out_last=1, the block SHALL return to IDLE on the next cycle with out_valid=0.
REQ-029 start SHALL be ignored whenever busy=1, including the final DRAIN transfer cycle; the earliest new accept is the cycle after the return to IDLE.
REQ-030 In IDLE, ADDR and DATA, out_valid, out_bit and out_last SHALL be 0.
REQ-031 rd_surv SHALL be sampled only in DATA.
REQ-032 rd_time and rd_state SHALL hold their last values in IDLE and DRAIN.
REQ-033 Elaboration SHALL fail when L < 1, L > D or D < 2.

Reset
REQ-034 When rst=1, the block SHALL go to IDLE and clear step_cnt and the LIFO count.
REQ-035 When rst=1, the outputs SHALL be: busy=0, rd_time=0, rd_state=0, out_valid=0, out_bit=0, out_last=0.
REQ-036 Reset SHALL take precedence over start and abandon any traceback in progress; no partial window is emitted.

Verification (M=3, D=8, L=4)
REQ-037 Bit ordering: start_state=0, start_time=7; memory returns rd_surv=1 iff rd_state==0 -> step states 0,4,2,1,0,4,2,1; out_bit sequence 1,0,0,0; out_last on the 4th bit.
REQ-038 Time wrap: start_time=2 -> rd_time over the steps = 2,1,0,7,6,5,4,3.
REQ-039 Forced state: use_state0=1, start_state=5 -> first rd_state=0.
REQ-040 Latency: with out_ready=1, first out_valid exactly 16 cycles after the start-accept edge; busy falls 4 cycles after out_valid rises.
REQ-041 Backpressure: out_ready=0 for 3 cycles on bit 2 -> out_bit and out_last stable over those cycles, no bit lost or duplicated; start pulses during busy are ignored.
REQ-042 Mid-trace reset: rst in the 5th DATA cycle -> all outputs at reset values the next cycle; a subsequent start runs a complete, correct window.
